serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract controller. Reuses a single 1-bit full-adder cell

---
 rtl/serial_add_ctrl_pkg.sv | 18 +
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_add_ctrl_adder_1bit.sv | 16 +
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encodings and the bit-counter width helper.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must reach width-1; never narrower than one bit.
    function automatic int cntWidth(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the serial adder: the caller (master) drives the
// operands and start, the controller (slave) returns busy/done and results.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_add_ctrl_adder_1bit.sv
// Single full-adder cell; the serial controller reuses it once per bit.
module adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    // Plain combinational full adder.
    always_comb begin
        s_o  = a_i ^ b_i ^ ci_i;
        co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is stepped over
// WIDTH cycles, LSB first, behind a start/busy/done handshake.
// Optional feature macro: SERIAL_ADD_SAT_EN -- clamps the sum on signed
// overflow (cout and ovf still report the raw result).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);

    localparam int CNT_W = cntWidth(WIDTH);

    state_t             state_q;
    state_t             state_d;
    // Operand A register doubles as the result shift register: each RUN edge
    // consumes bit 0 and shifts the new sum bit in at the MSB, so after WIDTH
    // edges it holds the complete result.
    logic [WIDTH-1:0]   shiftA_q;
    logic [WIDTH-1:0]   opB_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               cellS;
    logic               cellCo;
    logic               lastBit;
    logic               ovfNext;
    logic [WIDTH-1:0]   resNext;
    logic [WIDTH-1:0]   sumFinal;

    adder_1bit u_cell (
        .a_i  (shiftA_q[0]),
        .b_i  (opB_q[0]),
        .ci_i (carry_q),
        .s_o  (cellS),
        .co_o (cellCo)
    );

    assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));

    // Final-bit result: complete sum word, overflow, and optional clamp.
    // At the last bit shiftA_q[0] is still the original MSB of operand A,
    // which tells positive from negative overflow.
    always_comb begin
        resNext  = {cellS, shiftA_q[WIDTH-1:1]};
        ovfNext  = carry_q ^ cellCo;
        sumFinal = resNext;
`ifdef SERIAL_ADD_SAT_EN
        if (ovfNext) begin
            sumFinal = shiftA_q[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE on the MSB, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (lastBit)   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on start, step one bit per RUN edge, and load
    // the visible results on the MSB edge so they hold after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftA_q <= '0;
            opB_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        shiftA_q <= bus.a;
                        opB_q    <= bus.sub ? ~bus.b : bus.b;
                        carry_q  <= bus.sub;
                        cnt_q    <= '0;
                    end
                end
                ST_RUN: begin
                    shiftA_q <= resNext;
                    opB_q    <= opB_q >> 1;
                    carry_q  <= cellCo;
                    if (lastBit) begin
                        sum_q  <= sumFinal;
                        cout_q <= cellCo;
                        ovf_q  <= ovfNext;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8) with hand-computed results.
// Honours SERIAL_ADD_SAT_EN for the expected clamped sums.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Present a request for one edge, then scramble the operands so any late
    // sampling would corrupt the result. Returns #1 after the sampling edge.
    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] aa,
                                 input logic [WIDTH-1:0] bb);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = aa;
        bus.b     = bb;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.sub   = ~s;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
    endtask

    // Run one operation, optionally re-pulsing start while busy, and check
    // latency, single done pulse, results, and hold-after-done.
    task automatic runOp(input string tag, input logic s, input logic [WIDTH-1:0] aa,
                         input logic [WIDTH-1:0] bb, input logic [WIDTH-1:0] expSum,
                         input logic expCout, input logic expOvf, input bit repulse);
        int lat;
        int dones;
        logic [WIDTH-1:0] sumAtDone;
        logic coutAtDone;
        logic ovfAtDone;
        logic busyAtDone;
        lat = 0;
        dones = 0;
        sumAtDone = '0;
        coutAtDone = 1'b0;
        ovfAtDone = 1'b0;
        busyAtDone = 1'b0;
        applyStimulus(s, aa, bb);
        checkOutput({tag, "_busy_run"}, {31'd0, bus.busy}, 32'd1);
        for (int i = 1; i <= 2 * WIDTH + 4; i++) begin
            if (repulse && i == 2) begin
                bus.start = 1'b1;
                bus.a     = 8'h11;
                bus.b     = 8'h22;
            end
            if (repulse && i == 4) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (lat == 0) begin
                    lat        = i;
                    sumAtDone  = bus.sum;
                    coutAtDone = bus.cout;
                    ovfAtDone  = bus.ovf;
                    busyAtDone = bus.busy;
                end
            end
        end
        checkOutput({tag, "_latency"}, lat, WIDTH);
        checkOutput({tag, "_donePulses"}, dones, 1);
        checkOutput({tag, "_busy_done"}, {31'd0, busyAtDone}, 32'd1);
        checkOutput({tag, "_sum"}, {24'd0, sumAtDone}, {24'd0, expSum});
        checkOutput({tag, "_cout"}, {31'd0, coutAtDone}, {31'd0, expCout});
        checkOutput({tag, "_ovf"}, {31'd0, ovfAtDone}, {31'd0, expOvf});
        checkOutput({tag, "_busy_idle"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, "_sum_held"}, {24'd0, bus.sum}, {24'd0, expSum});
    endtask

    // Main directed sequence.
    initial begin
        logic [WIDTH-1:0] expPosOvf;
        logic [WIDTH-1:0] expNegOvf;
`ifdef SERIAL_ADD_SAT_EN
        expPosOvf = 8'h7F;
        expNegOvf = 8'h80;
`else
        expPosOvf = 8'h80;
        expNegOvf = 8'h7F;
`endif
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.sub     = 1'b0;
        bus.a       = '0;
        bus.b       = '0;

        #2 rst = 1'b1;
        #5;
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_sum",  {24'd0, bus.sum}, 32'd0);
        checkOutput("reset_cout", {31'd0, bus.cout}, 32'd0);
        checkOutput("reset_ovf",  {31'd0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        runOp("add_basic",  1'b0, 8'h3C, 8'h05, 8'h41,     1'b0, 1'b0, 1'b0);
        runOp("add_posovf", 1'b0, 8'h7F, 8'h01, expPosOvf, 1'b0, 1'b1, 1'b0);
        runOp("add_negovf", 1'b0, 8'h80, 8'hFF, expNegOvf, 1'b1, 1'b1, 1'b0);
        runOp("sub_borrow", 1'b1, 8'h05, 8'h07, 8'hFE,     1'b0, 1'b0, 1'b0);
        runOp("sub_noborr", 1'b1, 8'h07, 8'h05, 8'h02,     1'b1, 1'b0, 1'b0);
        runOp("add_wrap",   1'b0, 8'hFF, 8'h01, 8'h00,     1'b1, 1'b0, 1'b0);
        runOp("add_repuls", 1'b0, 8'h12, 8'h34, 8'h46,     1'b0, 1'b0, 1'b1);

        // Abort mid-RUN with an asynchronous reset between clock edges.
        applyStimulus(1'b0, 8'h3C, 8'h05);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort_done", {31'd0, bus.done}, 32'd0);
        checkOutput("abort_sum",  {24'd0, bus.sum}, 32'd0);
        checkOutput("abort_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        checkOutput("abort_noDone", {31'd0, bus.done}, 32'd0);
        checkOutput("abort_idle",   {31'd0, bus.busy}, 32'd0);
        runOp("after_abort", 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
